// File: rtl/memory_game_pkg.sv
// memory_game_pkg
//   Shared definitions for the memory-game blocks: the default sequence
//   length, the default pattern (also used by the level checker), the
//   presenter FSM state encoding and a helper that sizes the dwell counter.
package memory_game_pkg;

    localparam int SEQ_LEN_DEFAULT = 9;

    // Default pattern. The presenter plays it and the level checker expects it.
    localparam logic [SEQ_LEN_DEFAULT-1:0] DEFAULT_SEQUENCE = 9'b101010101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } pres_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width that holds every count from 0 up to the larger of the two dwells.
    function automatic int dwell_width(input int hold_cycles, input int gap_cycles);
        int w;
        w = $clog2(max_int(hold_cycles, gap_cycles) + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// dwell_counter
//   Counts clock cycles spent in the current presenter state. The count
//   starts at 0 and restarts whenever clear is high. tc flags the last cycle
//   of the dwell: HOLD_TC in SHOW (gap_sel=0) or GAP_TC in GAP (gap_sel=1).
//   Ports:
//     clk      in   system clock, rising edge
//     reset_n  in   asynchronous active-low reset
//     clear    in   restart the count from 0 on the next edge
//     gap_sel  in   select the GAP terminal count instead of the SHOW one
//     tc       out  count has reached the selected terminal value
module dwell_counter #(
    parameter int               WIDTH   = 2,
    parameter logic [WIDTH-1:0] HOLD_TC = '0,
    parameter logic [WIDTH-1:0] GAP_TC  = '0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic gap_sel,
    output logic tc
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

    assign tc = (count == (gap_sel ? GAP_TC : HOLD_TC));

endmodule

// File: rtl/seq_presenter.sv
// seq_presenter
//   Plays a captured SEQ_LEN-bit sequence out MSB first. Each element is
//   shown for HOLD_CYCLES cycles, with GAP_CYCLES blank cycles between
//   elements (none after the last one), followed by a one-cycle done pulse.
//
//   Handshake: start is a request that is accepted only in IDLE (busy=0);
//   while busy it is ignored, so busy acts as the inverse of a ready.
//   bit_valid is a pure strobe with no back-pressure: the display driver
//   shows bit_out whenever bit_valid is high. abort is a synchronous cancel
//   that wins over every other transition outside IDLE and never yields done.
//
//   Ports:
//     clk        in   system clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     start      in   playback request, sampled only in IDLE
//     abort      in   cancel playback, back to IDLE without done
//     seq_in     in   sequence captured on an accepted start
//     bit_valid  out  an element is being displayed
//     bit_out    out  displayed element value, 0 when bit_valid=0
//     index      out  position being shown, SEQ_LEN-1 down to 0
//     busy       out  high in SHOW, GAP and DONE
//     done       out  one-cycle pulse on the last busy cycle
//     state      out  current FSM state (observability)
module seq_presenter
    import memory_game_pkg::*;
#(
    parameter int SEQ_LEN     = SEQ_LEN_DEFAULT,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int GAP_CYCLES  = 25_000_000,
    localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SEQ_LEN-1:0] seq_in,
    output logic               bit_valid,
    output logic               bit_out,
    output logic [IW-1:0]      index,
    output logic               busy,
    output logic               done,
    output pres_state_t        state
);

    localparam int            DW       = dwell_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [DW-1:0] HOLD_TC  = DW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] GAP_TC   = (GAP_CYCLES > 0) ? DW'(GAP_CYCLES - 1) : '0;
    localparam logic [IW-1:0] IDX_TOP  = IW'(SEQ_LEN - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic [SEQ_LEN-1:0] seq_q;
    logic [IW-1:0]      index_dec;
    logic               dwell_clear;
    logic               dwell_tc;

    assign index_dec = index - IDX_ONE;

    // The dwell restarts on every state change and on the SHOW->SHOW
    // element step used when there is no gap; all of those coincide with
    // tc, abort, or being outside SHOW/GAP.
    assign dwell_clear = ((state != SHOW) && (state != GAP)) || abort || dwell_tc;

    dwell_counter #(
        .WIDTH   (DW),
        .HOLD_TC (HOLD_TC),
        .GAP_TC  (GAP_TC)
    ) u_dwell (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (dwell_clear),
        .gap_sel (state == GAP),
        .tc      (dwell_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            seq_q     <= '0;
            index     <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if ((state != IDLE) && abort) begin
                state     <= IDLE;
                index     <= '0;
                bit_valid <= 1'b0;
                bit_out   <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            seq_q     <= seq_in;
                            index     <= IDX_TOP;
                            bit_valid <= 1'b1;
                            bit_out   <= seq_in[SEQ_LEN-1];
                            busy      <= 1'b1;
                            state     <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (dwell_tc) begin
                            if (index == '0) begin
                                // Last element: no trailing gap.
                                state     <= DONE;
                                bit_valid <= 1'b0;
                                bit_out   <= 1'b0;
                                done      <= 1'b1;
                            end else if (GAP_CYCLES > 0) begin
                                state     <= GAP;
                                bit_valid <= 1'b0;
                                bit_out   <= 1'b0;
                            end else begin
                                index   <= index_dec;
                                bit_out <= seq_q[index_dec];
                            end
                        end
                    end
                    GAP: begin
                        if (dwell_tc) begin
                            state     <= SHOW;
                            index     <= index_dec;
                            bit_valid <= 1'b1;
                            bit_out   <= seq_q[index_dec];
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_presenter.sv
module tb_seq_presenter;
    import memory_game_pkg::*;

    localparam int LEN  = 9;
    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic reset_n;

    logic           start_a, abort_a, start_b, abort_b;
    logic [LEN-1:0] seq_in_a, seq_in_b;
    logic           a_bit_valid, a_bit_out, a_busy, a_done;
    logic           b_bit_valid, b_bit_out, b_busy, b_done;
    logic [3:0]     a_index, b_index;
    pres_state_t    a_state, b_state;

    // Expected per-busy-cycle entries: {bit_valid, index[3:0], bit_out, done}
    logic [6:0] a_q[$];
    logic [6:0] b_q[$];
    logic [6:0] a_e, b_e;

    int n_checks = 0;
    int n_fail   = 0;

    seq_presenter #(.SEQ_LEN(LEN), .HOLD_CYCLES(HOLD), .GAP_CYCLES(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .abort(abort_a), .seq_in(seq_in_a),
        .bit_valid(a_bit_valid), .bit_out(a_bit_out), .index(a_index), .busy(a_busy),
        .done(a_done), .state(a_state)
    );

    seq_presenter #(.SEQ_LEN(LEN), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .abort(abort_b), .seq_in(seq_in_b),
        .bit_valid(b_bit_valid), .bit_out(b_bit_out), .index(b_index), .busy(b_busy),
        .done(b_done), .state(b_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_entry(input bit to_b, input logic [6:0] e);
        if (to_b) b_q.push_back(e);
        else      a_q.push_back(e);
    endtask

    // Expected busy-cycle stream of one playback: HOLD cycles per element,
    // gap_len blank cycles between elements, then one done cycle.
    task automatic push_play(input bit to_b, input int gap_len, input logic [LEN-1:0] seq);
        for (int i = LEN - 1; i >= 0; i--) begin
            for (int h = 0; h < HOLD; h++) push_entry(to_b, {1'b1, 4'(i), seq[i], 1'b0});
            if (i > 0)
                for (int g = 0; g < gap_len; g++) push_entry(to_b, {1'b0, 4'(i), 1'b0, 1'b0});
        end
        push_entry(to_b, {1'b0, 4'd0, 1'b0, 1'b1});
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (a_busy) begin
            if (a_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL a_unexpected_busy: got busy=1 expected idle at %0t", $time);
            end else begin
                a_e = a_q.pop_front();
                check("a_stream", {a_bit_valid, a_index, a_bit_out, a_done}, a_e);
            end
        end else begin
            check("a_idle_outputs", {a_bit_valid, a_index, a_bit_out, a_done}, 0);
        end
    end

    always @(negedge clk) begin
        if (b_busy) begin
            if (b_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL b_unexpected_busy: got busy=1 expected idle at %0t", $time);
            end else begin
                b_e = b_q.pop_front();
                check("b_stream", {b_bit_valid, b_index, b_bit_out, b_done}, b_e);
            end
        end else begin
            check("b_idle_outputs", {b_bit_valid, b_index, b_bit_out, b_done}, 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Counts negedges until done; exp_lat < 0 only requires that done appears.
    task automatic wait_done(input bit on_b, input int exp_lat, input string name);
        int  n    = 0;
        bit  seen = 0;
        while (!seen && n < 300) begin
            @(negedge clk); #1;
            n++;
            if (on_b ? b_done : a_done) seen = 1;
        end
        if (exp_lat < 0) check(name, 32'(seen), 1);
        else             check(name, n, exp_lat);
    endtask

    task automatic play_and_wait(input bit on_b, input logic [LEN-1:0] seq,
                                 input int exp_lat, input string name);
        int  n    = 0;
        bit  seen = 0;
        if (on_b) begin start_b = 1'b1; seq_in_b = seq; push_play(1, 0, seq); end
        else      begin start_a = 1'b1; seq_in_a = seq; push_play(0, 2, seq); end
        while (!seen && n < 300) begin
            @(negedge clk); #1;
            n++;
            start_a = 1'b0;
            start_b = 1'b0;
            if (on_b ? b_done : a_done) seen = 1;
        end
        check(name, n, exp_lat);
    endtask

    task automatic wait_a_show(input logic [3:0] idx, input string name);
        int n = 0;
        while (!(a_bit_valid && a_index == idx) && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        check(name, 32'(a_bit_valid && a_index == idx), 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_n  = 1'b0;
        start_a  = 1'b0; abort_a = 1'b0; seq_in_a = '0;
        start_b  = 1'b0; abort_b = 1'b0; seq_in_b = '0;
        repeat (2) @(negedge clk);
        #1;
        check("a_reset_state", {a_busy, a_bit_valid, a_bit_out, a_done, a_index, 2'(a_state)}, 0);
        check("b_reset_state", {b_busy, b_bit_valid, b_bit_out, b_done, b_index, 2'(b_state)}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;

        // Basic playback, HOLD=3 GAP=2: done on the 44th busy cycle.
        play_and_wait(0, DEFAULT_SEQUENCE, 44, "a_done_latency");
        @(negedge clk); #1;
        check("a_busy_falls_after_done", 32'(a_busy), 0);

        // GAP=0: 27 contiguous valid cycles, done on the 28th.
        play_and_wait(1, 9'b101010101, 28, "b_done_latency");
        @(negedge clk); #1;
        check("b_busy_falls_after_done", 32'(b_busy), 0);

        // Abort during the 4th element (index 5).
        start_a = 1'b1; seq_in_a = 9'b110011010; push_play(0, 2, 9'b110011010);
        @(negedge clk); #1;
        start_a = 1'b0;
        wait_a_show(4'd5, "abort_reach_index5");
        abort_a = 1'b1;
        a_q.delete();
        @(negedge clk); #1;
        abort_a = 1'b0;
        check("abort_to_idle", {a_busy, a_done, 2'(a_state)}, {1'b0, 1'b0, 2'(IDLE)});
        repeat (3) @(negedge clk);
        #1;
        play_and_wait(0, 9'b110011010, 44, "replay_after_abort");
        @(negedge clk); #1;

        // Start while busy (at index 4) with a different pattern is ignored.
        start_a = 1'b1; seq_in_a = 9'b100110011; push_play(0, 2, 9'b100110011);
        @(negedge clk); #1;
        start_a = 1'b0;
        wait_a_show(4'd4, "ignore_reach_index4");
        start_a = 1'b1; seq_in_a = 9'b011001100;
        @(negedge clk); #1;
        start_a = 1'b0;
        wait_done(0, -1, "ignored_start_done");
        check("ignored_start_drained", a_q.size(), 0);
        @(negedge clk); #1;
        check("ignored_start_idle", 32'(a_busy), 0);

        // Start held high: two playbacks separated by exactly one IDLE cycle.
        start_a = 1'b1; seq_in_a = 9'b111000101;
        push_play(0, 2, 9'b111000101);
        push_play(0, 2, 9'b111000101);
        wait_done(0, 44, "held_first_done");
        @(negedge clk); #1;
        check("held_one_idle_cycle", {a_busy, 2'(a_state)}, {1'b0, 2'(IDLE)});
        @(negedge clk); #1;
        check("held_restart", {a_bit_valid, a_index}, {1'b1, 4'd8});
        start_a = 1'b0;
        wait_done(0, 43, "held_second_done");
        @(negedge clk); #1;

        // Asynchronous reset pulse in the middle of a GAP.
        start_a = 1'b1; seq_in_a = DEFAULT_SEQUENCE; push_play(0, 2, DEFAULT_SEQUENCE);
        @(negedge clk); #1;
        start_a = 1'b0;
        begin
            int n = 0;
            while (a_state != GAP && n < 100) begin
                @(negedge clk); #1;
                n++;
            end
            check("reach_gap", 32'(a_state == GAP), 1);
        end
        #2;
        reset_n = 1'b0;
        a_q.delete();
        b_q.delete();
        #1;
        check("async_reset_outputs", {a_busy, a_bit_valid, a_bit_out, a_done, a_index}, 0);
        #9;
        reset_n = 1'b1;
        @(negedge clk); #1;
        check("idle_after_reset", {a_busy, 2'(a_state)}, {1'b0, 2'(IDLE)});
        repeat (6) @(negedge clk);
        #1;

        check("a_queue_empty", a_q.size(), 0);
        check("b_queue_empty", b_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
